// File: rtl/softmax_wdma_pkg.sv
// Shared definitions for the softmax write-DMA: beat and burst geometry,
// CSR field widths, FSM states and the MCIF command layout.
package softmax_wdma_pkg;

   localparam int TOUT       = 8;
   localparam int MAX_DAT_DW = 64;
   localparam int DAT_W      = TOUT * MAX_DAT_DW;
   localparam int BEAT_BYTES = DAT_W / 8;
   localparam int BURST_LEN  = 16;
   localparam int LOG2_BURST = 4;

   localparam int LOG2_CH    = 11;
   localparam int LOG2_TOUT  = 3;
   localparam int CH_W       = LOG2_CH - LOG2_TOUT;
   localparam int H_W        = 11;
   localparam int W_W        = 11;
   localparam int WCHUNK_W   = W_W - LOG2_BURST;
   localparam int REQ_W      = LOG2_BURST + 32;

   localparam logic [31:0] W_STEP = 32'(BURST_LEN * BEAT_BYTES);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CMD,
      ST_DATA
   } wdma_state_t;

   // Command payload is {len, addr}; the read DMA uses the same layout.
   function automatic logic [REQ_W-1:0] pack_cmd(input logic [LOG2_BURST-1:0] len,
                                                 input logic [31:0]           addr);
      return {len, addr};
   endfunction

endpackage

// File: rtl/softmax_wdma_if.sv
// Core-to-DMA data stream plus the MCIF write command and data channels.
interface softmax_wdma_if;
   import softmax_wdma_pkg::*;

   logic             core2wdma_dat_vld;
   logic             core2wdma_dat_rdy;
   logic [DAT_W-1:0] core2wdma_dat_pd;

   logic             Softmax2mcif_wr_req_vld;
   logic             Softmax2mcif_wr_req_rdy;
   logic [REQ_W-1:0] Softmax2mcif_wr_req_pd;

   logic             Softmax2mcif_wr_dat_vld;
   logic             Softmax2mcif_wr_dat_rdy;
   logic [DAT_W-1:0] Softmax2mcif_wr_dat_pd;
   logic             Softmax2mcif_wr_dat_last;

   modport master (
      input  core2wdma_dat_vld, core2wdma_dat_pd,
      input  Softmax2mcif_wr_req_rdy, Softmax2mcif_wr_dat_rdy,
      output core2wdma_dat_rdy,
      output Softmax2mcif_wr_req_vld, Softmax2mcif_wr_req_pd,
      output Softmax2mcif_wr_dat_vld, Softmax2mcif_wr_dat_pd, Softmax2mcif_wr_dat_last
   );

   modport slave (
      output core2wdma_dat_vld, core2wdma_dat_pd,
      output Softmax2mcif_wr_req_rdy, Softmax2mcif_wr_dat_rdy,
      input  core2wdma_dat_rdy,
      input  Softmax2mcif_wr_req_vld, Softmax2mcif_wr_req_pd,
      input  Softmax2mcif_wr_dat_vld, Softmax2mcif_wr_dat_pd, Softmax2mcif_wr_dat_last
   );

endinterface

// File: rtl/softmax_wdma_addr_gen.sv
// Nested CH / w-chunk / h walk over the output surface, producing the
// address and length of the current burst and the end-of-surface flag.
module softmax_wdma_addr_gen
   import softmax_wdma_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_clear,
   input  logic                  i_advance,
   input  logic [31:0]           i_base,
   input  logic [25:0]           i_surface_stride,
   input  logic [15:0]           i_line_stride,
   input  logic [CH_W-1:0]       i_ch_div,
   input  logic [H_W-1:0]        i_h_out,
   input  logic [W_W-1:0]        i_w_out,
   output logic [31:0]           o_cmd_addr,
   output logic [LOG2_BURST-1:0] o_cmd_len,
   output logic                  o_last_surface
);

   logic [CH_W-1:0]     r_ch_cnt;
   logic [WCHUNK_W-1:0] r_w_cnt;
   logic [H_W-1:0]      r_h_cnt;
   logic [31:0]         r_ch_bias;
   logic [31:0]         r_w_bias;
   logic [31:0]         r_h_bias;

   logic [W_W-1:0]      w_w_minus1;
   logic                w_ch_wrap;
   logic                w_w_wrap;
   logic                w_h_wrap;

   assign w_w_minus1 = i_w_out - W_W'(1);
   assign w_ch_wrap  = (r_ch_cnt == i_ch_div - CH_W'(1));
   assign w_w_wrap   = (r_w_cnt == w_w_minus1[W_W-1:LOG2_BURST]);
   assign w_h_wrap   = (r_h_cnt == i_h_out - H_W'(1));

   // Only the final w chunk of a row can be short.
   assign o_cmd_len      = w_w_wrap ? w_w_minus1[LOG2_BURST-1:0] : LOG2_BURST'(BURST_LEN - 1);
   assign o_cmd_addr     = i_base + r_h_bias + r_w_bias + r_ch_bias;
   assign o_last_surface = w_ch_wrap & w_w_wrap & w_h_wrap;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ch_cnt  <= '0;
         r_w_cnt   <= '0;
         r_h_cnt   <= '0;
         r_ch_bias <= '0;
         r_w_bias  <= '0;
         r_h_bias  <= '0;
      end else if (i_clear) begin
         r_ch_cnt  <= '0;
         r_w_cnt   <= '0;
         r_h_cnt   <= '0;
         r_ch_bias <= '0;
         r_w_bias  <= '0;
         r_h_bias  <= '0;
      end else if (i_advance) begin
         if (!w_ch_wrap) begin
            r_ch_cnt  <= r_ch_cnt + CH_W'(1);
            r_ch_bias <= r_ch_bias + {6'd0, i_surface_stride};
         end else begin
            r_ch_cnt  <= '0;
            r_ch_bias <= '0;
            if (!w_w_wrap) begin
               r_w_cnt  <= r_w_cnt + WCHUNK_W'(1);
               r_w_bias <= r_w_bias + W_STEP;
            end else begin
               r_w_cnt  <= '0;
               r_w_bias <= '0;
               if (!w_h_wrap) begin
                  r_h_cnt  <= r_h_cnt + H_W'(1);
                  r_h_bias <= r_h_bias + {16'd0, i_line_stride};
               end else begin
                  r_h_cnt  <= '0;
                  r_h_bias <= '0;
               end
            end
         end
      end
   end

endmodule

// File: rtl/softmax_wdma.sv
// Softmax write-DMA: issues one MCIF write command per burst and passes the
// core's output beats straight through behind it, pulsing done at the end.
module softmax_wdma
   import softmax_wdma_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_start,
   input  logic [31:0]       i_base_addr,
   input  logic [25:0]       i_surface_stride,
   input  logic [15:0]       i_line_stride,
   input  logic [CH_W-1:0]   i_ch_out_div_tout,
   input  logic [H_W-1:0]    i_h_out,
   input  logic [W_W-1:0]    i_w_out,
   output logic              o_done,
   softmax_wdma_if.master    bus
);

   wdma_state_t           r_state;
   wdma_state_t           w_next_state;
   logic [LOG2_BURST-1:0] r_beat_cnt;
   logic                  r_done;

   logic [31:0]           r_base;
   logic [25:0]           r_surface_stride;
   logic [15:0]           r_line_stride;
   logic [CH_W-1:0]       r_ch_div;
   logic [H_W-1:0]        r_h_out;
   logic [W_W-1:0]        r_w_out;

   logic                  w_clear;
   logic                  w_req_fire;
   logic                  w_beat_fire;
   logic                  w_last_beat;
   logic                  w_advance;
   logic                  w_req_vld;
   logic                  w_dat_vld;
   logic                  w_core_rdy;
   logic [31:0]           w_cmd_addr;
   logic [LOG2_BURST-1:0] w_cmd_len;
   logic                  w_last_surface;

   softmax_wdma_addr_gen u_addr_gen (
      .clk              (clk),
      .rst_n            (rst_n),
      .i_clear          (w_clear),
      .i_advance        (w_advance),
      .i_base           (r_base),
      .i_surface_stride (r_surface_stride),
      .i_line_stride    (r_line_stride),
      .i_ch_div         (r_ch_div),
      .i_h_out          (r_h_out),
      .i_w_out          (r_w_out),
      .o_cmd_addr       (w_cmd_addr),
      .o_cmd_len        (w_cmd_len),
      .o_last_surface   (w_last_surface)
   );

   assign w_clear     = (r_state == ST_IDLE) & i_start;
   assign w_req_fire  = w_req_vld & bus.Softmax2mcif_wr_req_rdy;
   assign w_beat_fire = (r_state == ST_DATA) & bus.core2wdma_dat_vld & bus.Softmax2mcif_wr_dat_rdy;
   assign w_last_beat = (r_beat_cnt == w_cmd_len);
   assign w_advance   = w_beat_fire & w_last_beat;

   always_comb begin
      w_next_state = r_state;
      w_req_vld    = 1'b0;
      w_dat_vld    = 1'b0;
      w_core_rdy   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (i_start) w_next_state = ST_CMD;
         end
         ST_CMD: begin
            w_req_vld = 1'b1;
            if (bus.Softmax2mcif_wr_req_rdy) w_next_state = ST_DATA;
         end
         ST_DATA: begin
            w_dat_vld  = bus.core2wdma_dat_vld;
            w_core_rdy = bus.Softmax2mcif_wr_dat_rdy;
            if (w_advance) w_next_state = w_last_surface ? ST_IDLE : ST_CMD;
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_beat_cnt <= '0;
         r_done     <= 1'b0;
      end else begin
         r_state <= w_next_state;
         r_done  <= w_advance & w_last_surface;
         if (w_req_fire)       r_beat_cnt <= '0;
         else if (w_beat_fire) r_beat_cnt <= r_beat_cnt + LOG2_BURST'(1);
      end
   end

   // Surface geometry is frozen at start so CSR writes mid-surface are harmless.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_base           <= '0;
         r_surface_stride <= '0;
         r_line_stride    <= '0;
         r_ch_div         <= '0;
         r_h_out          <= '0;
         r_w_out          <= '0;
      end else if (w_clear) begin
         r_base           <= i_base_addr;
         r_surface_stride <= i_surface_stride;
         r_line_stride    <= i_line_stride;
         r_ch_div         <= i_ch_out_div_tout;
         r_h_out          <= i_h_out;
         r_w_out          <= i_w_out;
      end
   end

   assign bus.Softmax2mcif_wr_req_vld  = w_req_vld;
   assign bus.Softmax2mcif_wr_req_pd   = pack_cmd(w_cmd_len, w_cmd_addr);
   assign bus.Softmax2mcif_wr_dat_vld  = w_dat_vld;
   assign bus.Softmax2mcif_wr_dat_pd   = bus.core2wdma_dat_pd;
   assign bus.Softmax2mcif_wr_dat_last = (r_state == ST_DATA) & w_last_beat;
   assign bus.core2wdma_dat_rdy        = w_core_rdy;
   assign o_done                       = r_done;

endmodule

// File: tb/tb_softmax_wdma.sv
// Scoreboard bench for softmax_wdma: a loop-nest surface model queues the
// expected commands and beats; a negedge monitor pops and compares them.
module tb_softmax_wdma;
   import softmax_wdma_pkg::*;

   typedef struct {
      logic [DAT_W-1:0] data;
      logic             last;
      logic             endSurf;
   } beat_t;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            i_start = 1'b0;
   logic [31:0]     i_base_addr = '0;
   logic [25:0]     i_surface_stride = '0;
   logic [15:0]     i_line_stride = '0;
   logic [CH_W-1:0] i_ch_out_div_tout = '0;
   logic [H_W-1:0]  i_h_out = '0;
   logic [W_W-1:0]  i_w_out = '0;
   logic            o_done;

   softmax_wdma_if bus ();

   softmax_wdma dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .i_start           (i_start),
      .i_base_addr       (i_base_addr),
      .i_surface_stride  (i_surface_stride),
      .i_line_stride     (i_line_stride),
      .i_ch_out_div_tout (i_ch_out_div_tout),
      .i_h_out           (i_h_out),
      .i_w_out           (i_w_out),
      .o_done            (o_done),
      .bus               (bus)
   );

   always #5 clk = ~clk;

   logic [REQ_W-1:0] cmdQ[$];
   beat_t            expQ[$];
   logic [DAT_W-1:0] srcQ[$];
   beat_t            monBeat;

   int  totalChecks = 0;
   int  badChecks = 0;
   int  vldPct = 100;
   int  rdyPct = 100;
   int  reqPct = 100;
   int  reqLow = 0;
   bit  coreFire = 1'b0;
   bit  expectDoneNext = 1'b0;
   int  doneCount = 0;
   int  cmdSeen = 0;
   int  beatSeen = 0;
   int  modelCmds = 0;
   int  modelBeats = 0;

   task automatic checkOutput(input string name, input logic [DAT_W-1:0] act,
                              input logic [DAT_W-1:0] exp);
      totalChecks++;
      if (act !== exp) begin
         badChecks++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic failNow(input string name);
      totalChecks++;
      badChecks++;
      $display("[TB] FAIL %s: got event expected none", name);
   endtask

   function automatic logic [DAT_W-1:0] randWord();
      logic [DAT_W-1:0] r;
      for (int k = 0; k < DAT_W / 32; k++) r[k*32 +: 32] = $urandom;
      return r;
   endfunction

   // Reference walk: rows outermost, then 16-pixel chunks, then CH groups.
   task automatic buildSurface(input logic [31:0] base, input logic [31:0] surf,
                               input logic [31:0] line, input int ch, input int h,
                               input int w);
      int          lastChunk;
      int          beats;
      logic [31:0] addr;
      beat_t       bt;
      lastChunk  = (w - 1) / BURST_LEN;
      modelCmds  = 0;
      modelBeats = 0;
      for (int hh = 0; hh < h; hh++) begin
         for (int wc = 0; wc <= lastChunk; wc++) begin
            for (int c = 0; c < ch; c++) begin
               beats = (w - wc * BURST_LEN > BURST_LEN) ? BURST_LEN : (w - wc * BURST_LEN);
               addr  = base + 32'(hh) * line + 32'(wc * BURST_LEN * BEAT_BYTES) + 32'(c) * surf;
               cmdQ.push_back({LOG2_BURST'(beats - 1), addr});
               modelCmds++;
               for (int b = 0; b < beats; b++) begin
                  bt.data    = randWord();
                  bt.last    = (b == beats - 1);
                  bt.endSurf = (hh == h - 1) && (wc == lastChunk) && (c == ch - 1) && (b == beats - 1);
                  srcQ.push_back(bt.data);
                  expQ.push_back(bt);
                  modelBeats++;
               end
            end
         end
      end
   endtask

   task automatic applyStimulus(input logic [31:0] base, input logic [31:0] surf,
                                input logic [31:0] line, input int ch, input int h,
                                input int w);
      doneCount = 0;
      cmdSeen   = 0;
      beatSeen  = 0;
      i_base_addr       = base;
      i_surface_stride  = surf[25:0];
      i_line_stride     = line[15:0];
      i_ch_out_div_tout = CH_W'(ch);
      i_h_out           = H_W'(h);
      i_w_out           = W_W'(w);
      buildSurface(base, surf, line, ch, h, w);
      @(posedge clk); #2;
      i_start = 1'b1;
      @(posedge clk); #2;
      i_start = 1'b0;
   endtask

   task automatic flushModel();
      cmdQ.delete();
      expQ.delete();
      srcQ.delete();
      expectDoneNext = 1'b0;
   endtask

   task automatic doReset();
      @(posedge clk); #2;
      rst_n = 1'b0;
      flushModel();
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b1;
   endtask

   task automatic waitSurface(input string name);
      int cyc = 0;
      while ((cmdQ.size() != 0 || expQ.size() != 0 || expectDoneNext) && cyc < 5000) begin
         @(posedge clk);
         cyc++;
      end
      if (cyc >= 5000) begin
         failNow({name, "_timeout"});
         doReset();
      end
      repeat (3) @(posedge clk);
      #2;
      checkOutput({name, "_done_count"}, DAT_W'(doneCount), DAT_W'(1));
      checkOutput({name, "_cmd_count"}, DAT_W'(cmdSeen), DAT_W'(modelCmds));
      checkOutput({name, "_beat_count"}, DAT_W'(beatSeen), DAT_W'(modelBeats));
   endtask

   task automatic checkAllIdle(input string name);
      checkOutput({name, "_req_vld"}, DAT_W'(bus.Softmax2mcif_wr_req_vld), '0);
      checkOutput({name, "_dat_vld"}, DAT_W'(bus.Softmax2mcif_wr_dat_vld), '0);
      checkOutput({name, "_core_rdy"}, DAT_W'(bus.core2wdma_dat_rdy), '0);
      checkOutput({name, "_dat_last"}, DAT_W'(bus.Softmax2mcif_wr_dat_last), '0);
      checkOutput({name, "_done"}, DAT_W'(o_done), '0);
   endtask

   // Core source and MCIF ready generator; updates just after each rising edge.
   always begin
      @(posedge clk);
      #1;
      if (coreFire && srcQ.size() != 0) void'(srcQ.pop_front());
      coreFire = 1'b0;
      bus.core2wdma_dat_vld = (srcQ.size() != 0) && ($urandom_range(99) < vldPct);
      bus.core2wdma_dat_pd  = (srcQ.size() != 0) ? srcQ[0] : '0;
      bus.Softmax2mcif_wr_dat_rdy = ($urandom_range(99) < rdyPct);
      if (reqLow > 0) begin
         bus.Softmax2mcif_wr_req_rdy = 1'b0;
         reqLow--;
      end else begin
         bus.Softmax2mcif_wr_req_rdy = ($urandom_range(99) < reqPct);
      end
   end

   // Monitor: every transfer that completes on the next rising edge is scored here.
   always @(negedge clk) begin
      coreFire = bus.core2wdma_dat_vld && bus.core2wdma_dat_rdy;
      if (rst_n) begin
         if (expectDoneNext) begin
            checkOutput("done_pulse", DAT_W'(o_done), DAT_W'(1));
            expectDoneNext = 1'b0;
         end else if (o_done) begin
            failNow("done_spurious");
         end
         if (o_done) doneCount++;

         if (bus.Softmax2mcif_wr_req_vld) begin
            checkOutput("core_rdy_before_cmd", DAT_W'(bus.core2wdma_dat_rdy), '0);
            if (cmdQ.size() != 0) checkOutput("req_pd", DAT_W'(bus.Softmax2mcif_wr_req_pd), DAT_W'(cmdQ[0]));
            else failNow("req_unexpected");
            if (bus.Softmax2mcif_wr_req_rdy) begin
               if (cmdQ.size() != 0) void'(cmdQ.pop_front());
               cmdSeen++;
            end
         end

         if (bus.Softmax2mcif_wr_dat_vld && bus.Softmax2mcif_wr_dat_rdy) begin
            if (expQ.size() != 0) begin
               monBeat = expQ.pop_front();
               checkOutput("wr_dat_pd", bus.Softmax2mcif_wr_dat_pd, monBeat.data);
               checkOutput("wr_dat_last", DAT_W'(bus.Softmax2mcif_wr_dat_last), DAT_W'(monBeat.last));
               if (monBeat.endSurf) expectDoneNext = 1'b1;
            end else begin
               failNow("beat_unexpected");
            end
            beatSeen++;
         end
      end
   end

   initial begin
      int cyc;
      $display("[TB] softmax_wdma scoreboard bench");
      bus.core2wdma_dat_vld       = 1'b0;
      bus.core2wdma_dat_pd        = '0;
      bus.Softmax2mcif_wr_req_rdy = 1'b0;
      bus.Softmax2mcif_wr_dat_rdy = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      checkAllIdle("reset");
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #2;
      checkAllIdle("idle");

      $display("[TB] two CH groups, one full row");
      applyStimulus(32'h1000, 32'h4000, 32'h0, 2, 1, 16);
      waitSurface("t1");

      $display("[TB] short trailing chunk, two rows");
      applyStimulus(32'h0, 32'h0, 32'h500, 1, 2, 20);
      waitSurface("t2");

      $display("[TB] command ready held low");
      reqLow = 12;
      applyStimulus(32'h2000, 32'h800, 32'h0, 1, 1, 16);
      waitSurface("t3");

      $display("[TB] random data handshakes");
      vldPct = 60; rdyPct = 60; reqPct = 70;
      applyStimulus(32'hFFFF_F000, 32'h0001_0000, 32'h0900, 3, 2, 33);
      waitSurface("t4");
      checkOutput("t4_cmds", DAT_W'(cmdSeen), DAT_W'(18));
      checkOutput("t4_beats", DAT_W'(beatSeen), DAT_W'(198));
      vldPct = 100; rdyPct = 100; reqPct = 100;

      $display("[TB] reset in the middle of a burst");
      applyStimulus(32'h3000, 32'h4000, 32'h0, 1, 1, 16);
      cyc = 0;
      while (beatSeen < 7 && cyc < 2000) begin
         @(posedge clk);
         cyc++;
      end
      if (cyc >= 2000) failNow("t5_beat7_timeout");
      #2;
      rst_n = 1'b0;
      flushModel();
      #1;
      checkAllIdle("t5_reset");
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b1;
      applyStimulus(32'h3000, 32'h4000, 32'h0, 2, 1, 16);
      waitSurface("t5_restart");

      $display("[TB] start pulsed while busy");
      applyStimulus(32'h1000, 32'h4000, 32'h0, 2, 1, 16);
      repeat (4) @(posedge clk);
      #2;
      i_base_addr = 32'h7777_0000;
      i_start     = 1'b1;
      @(posedge clk); #2;
      i_start     = 1'b0;
      waitSurface("t6");

      $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
      $finish;
   end

endmodule
